// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared constants and helpers for the video pixel FIFO
package video_pkg;

   localparam int PIXEL_W_DEF = 8;

   typedef enum logic {
      MSB_FIRST = 1'b0,
      LSB_FIRST = 1'b1
   } pix_order_e;

   localparam pix_order_e PIX_ORDER = MSB_FIRST;

   function automatic int level_width(input int depth, input int word_pix);
      return $clog2(depth * word_pix + 1);
   endfunction

endpackage

// File: rtl/video_pixel_fifo_if.sv
// rtl/video_pixel_fifo_if.sv - word write handshake and pixel pop bus of the pixel FIFO
interface video_pixel_fifo_if
   import video_pkg::*;
#(
   parameter int PIXEL_W  = PIXEL_W_DEF,
   parameter int WORD_PIX = 2
);
   logic                          wr_valid;
   logic                          wr_ready;
   logic [PIXEL_W*WORD_PIX-1:0]   wr_data;
   logic                          pix_req;
   logic [PIXEL_W-1:0]            pix_out;
   logic                          pix_valid;

   modport master (
      output wr_valid, wr_data, pix_req,
      input  wr_ready, pix_out, pix_valid
   );

   modport slave (
      input  wr_valid, wr_data, pix_req,
      output wr_ready, pix_out, pix_valid
   );
endinterface

// File: rtl/video_fifo_mem.sv
// rtl/video_fifo_mem.sv - register-based word storage with asynchronous read
module video_fifo_mem
   import video_pkg::*;
#(
   parameter int WW    = 16,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [WW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [WW-1:0] rdata_o
);
   logic [WW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Head word must be visible in the same cycle for per-pixel slicing.
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/video_pixel_fifo.sv
// rtl/video_pixel_fifo.sv - packed-word FIFO that unpacks one pixel per request
module video_pixel_fifo
   import video_pkg::*;
#(
   parameter int PIXEL_W  = PIXEL_W_DEF,
   parameter int WORD_PIX = 2,
   parameter int DEPTH    = 4,
   parameter int LOW_WM   = 3
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    en,
   input  logic                                    flush,
   input  logic                                    clr_err,
   video_pixel_fifo_if.slave                       bus,
   output logic [level_width(DEPTH, WORD_PIX)-1:0] level,
   output logic                                    full,
   output logic                                    empty,
   output logic                                    low_wm,
   output logic                                    underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int WW = PIXEL_W * WORD_PIX;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (WORD_PIX > 1) ? $clog2(WORD_PIX) : 1;
   localparam int LW = level_width(DEPTH, WORD_PIX);

   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      wcnt_q, wcnt_d;
   logic [PW-1:0]      pidx_q, pidx_d;
   logic [LW-1:0]      level_q, level_d;
   logic [PIXEL_W-1:0] pix_out_q, pix_out_d;
   logic               pix_valid_q, pix_valid_d;
   logic               underflow_q, underflow_d;

   logic [WW-1:0]      head_word;
   logic [PIXEL_W-1:0] pix_sel;
   logic               wr_fire, pop_fire, under_ev, retire;

   assign full      = (wcnt_q == CW'(DEPTH));
   assign empty     = (level_q == '0);
   assign low_wm    = (level_q <= LW'(LOW_WM));
   assign level     = level_q;
   assign underflow = underflow_q;

   assign bus.wr_ready  = !full;
   assign bus.pix_out   = pix_out_q;
   assign bus.pix_valid = pix_valid_q;

   // wr_ready looks only at the registered count, so a same-cycle retire never frees a slot early.
   assign wr_fire  = en && bus.wr_valid && !full;
   assign pop_fire = en && bus.pix_req && !empty;
   assign under_ev = en && bus.pix_req && empty;
   assign retire   = pop_fire && (pidx_q == PW'(WORD_PIX - 1));

   video_fifo_mem #(
      .WW    (WW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_fire && !flush),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.wr_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (head_word)
   );

   always_comb begin
      pix_sel = '0;
      for (int i = 0; i < WORD_PIX; i++) begin
         if (pidx_q == PW'(i)) begin
            if (PIX_ORDER == MSB_FIRST) begin
               pix_sel = head_word[WW-1-PIXEL_W*i -: PIXEL_W];
            end else begin
               pix_sel = head_word[PIXEL_W*i +: PIXEL_W];
            end
         end
      end
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      wcnt_d      = wcnt_q;
      pidx_d      = pidx_q;
      level_d     = level_q;
      pix_out_d   = pix_out_q;
      pix_valid_d = 1'b0;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         wcnt_d   = '0;
         pidx_d   = '0;
         level_d  = '0;
      end else begin
         if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop_fire) begin
            pix_out_d   = pix_sel;
            pix_valid_d = 1'b1;
            if (retire) begin
               pidx_d   = '0;
               rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
               pidx_d = pidx_q + PW'(1);
            end
         end
         wcnt_d  = wcnt_q + CW'(wr_fire) - CW'(retire);
         level_d = level_q + (wr_fire ? LW'(WORD_PIX) : LW'(0)) - LW'(pop_fire);
      end

      // A fresh underflow event beats a simultaneous clear.
      if (under_ev) begin
         underflow_d = 1'b1;
      end else if (clr_err) begin
         underflow_d = 1'b0;
      end else begin
         underflow_d = underflow_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         wcnt_q      <= '0;
         pidx_q      <= '0;
         level_q     <= '0;
         pix_out_q   <= '0;
         pix_valid_q <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         wcnt_q      <= wcnt_d;
         pidx_q      <= pidx_d;
         level_q     <= level_d;
         pix_out_q   <= pix_out_d;
         pix_valid_q <= pix_valid_d;
         underflow_q <= underflow_d;
      end
   end
endmodule

// File: tb/tb_video_pixel_fifo.sv
// tb/tb_video_pixel_fifo.sv - self-checking bench for video_pixel_fifo
module tb_video_pixel_fifo;
   import video_pkg::*;

   localparam int DP  = 4;
   localparam int LWM = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b1;
   logic       flush = 1'b0;
   logic       clr_err = 1'b0;
   logic [3:0] level;
   logic       full, empty, low_wm, underflow;

   video_pixel_fifo_if #(.PIXEL_W(8), .WORD_PIX(2)) bus ();

   video_pixel_fifo #(
      .PIXEL_W  (8),
      .WORD_PIX (2),
      .DEPTH    (DP),
      .LOW_WM   (LWM)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .clr_err   (clr_err),
      .bus       (bus),
      .level     (level),
      .full      (full),
      .empty     (empty),
      .low_wm    (low_wm),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] sb[$];
   logic [7:0] m_pix;
   logic       m_pv;
   logic       m_uf;

   typedef struct {
      logic        wv;
      logic [15:0] wd;
      logic        req;
      int          lvl;
      logic        fl;
      logic        lw;
      logic [7:0]  px;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int  lvl;
      logic f;
      lvl = sb.size();
      f   = ((lvl + 1) / 2 == DP);
      chk({tag, ".level"}, int'(level), lvl);
      chk({tag, ".full"}, int'(full), int'(f));
      chk({tag, ".wr_ready"}, int'(bus.wr_ready), int'(!f));
      chk({tag, ".empty"}, int'(empty), int'(lvl == 0));
      chk({tag, ".low_wm"}, int'(low_wm), int'(lvl <= LWM));
      chk({tag, ".pix_valid"}, int'(bus.pix_valid), int'(m_pv));
      chk({tag, ".pix_out"}, int'(bus.pix_out), int'(m_pix));
      chk({tag, ".underflow"}, int'(underflow), int'(m_uf));
   endtask

   task automatic model_reset();
      sb.delete();
      m_pix = '0;
      m_pv  = 1'b0;
      m_uf  = 1'b0;
   endtask

   task automatic drive(input string tag, input logic wv, input logic [15:0] wd, input logic req);
      int   lvl;
      logic accw, pop, und;
      bus.wr_valid = wv;
      bus.wr_data  = wd;
      bus.pix_req  = req;
      lvl  = sb.size();
      accw = en && wv && ((lvl + 1) / 2 < DP);
      pop  = en && req && (lvl > 0);
      und  = en && req && (lvl == 0);
      @(posedge clk);
      #1;
      if (flush) begin
         sb.delete();
         m_pv = 1'b0;
      end else begin
         m_pv = pop;
         if (pop) m_pix = sb.pop_front();
         if (accw) begin
            sb.push_back(wd[15:8]);
            sb.push_back(wd[7:0]);
         end
      end
      if (und) m_uf = 1'b1;
      else if (clr_err) m_uf = 1'b0;
      check_all(tag);
      bus.wr_valid = 1'b0;
      bus.pix_req  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] saved;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.pix_req  = 1'b0;
      model_reset();

      tbl[0]  = '{1'b1, 16'hA1B2, 1'b0, 2, 1'b0, 1'b1, 8'h00};
      tbl[1]  = '{1'b1, 16'hC3D4, 1'b0, 4, 1'b0, 1'b0, 8'h00};
      tbl[2]  = '{1'b1, 16'hE5F6, 1'b0, 6, 1'b0, 1'b0, 8'h00};
      tbl[3]  = '{1'b1, 16'h0718, 1'b0, 8, 1'b1, 1'b0, 8'h00};
      tbl[4]  = '{1'b1, 16'h1234, 1'b0, 8, 1'b1, 1'b0, 8'h00};
      tbl[5]  = '{1'b0, 16'h0000, 1'b1, 7, 1'b1, 1'b0, 8'hA1};
      tbl[6]  = '{1'b0, 16'h0000, 1'b1, 6, 1'b0, 1'b0, 8'hB2};
      tbl[7]  = '{1'b0, 16'h0000, 1'b1, 5, 1'b0, 1'b0, 8'hC3};
      tbl[8]  = '{1'b0, 16'h0000, 1'b1, 4, 1'b0, 1'b0, 8'hD4};
      tbl[9]  = '{1'b0, 16'h0000, 1'b1, 3, 1'b0, 1'b1, 8'hE5};
      tbl[10] = '{1'b0, 16'h0000, 1'b1, 2, 1'b0, 1'b1, 8'hF6};
      tbl[11] = '{1'b0, 16'h0000, 1'b1, 1, 1'b0, 1'b1, 8'h07};
      tbl[12] = '{1'b0, 16'h0000, 1'b1, 0, 1'b0, 1'b1, 8'h18};

      #12;
      chk("rst.level", int'(level), 0);
      chk("rst.empty", int'(empty), 1);
      chk("rst.low_wm", int'(low_wm), 1);
      chk("rst.full", int'(full), 0);
      chk("rst.wr_ready", int'(bus.wr_ready), 1);
      @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 10; i++) drive("idle", 1'b0, 16'h0, 1'b0);

      for (int i = 0; i < 13; i++) begin
         drive("tbl", tbl[i].wv, tbl[i].wd, tbl[i].req);
         chk("tbl.level", int'(level), tbl[i].lvl);
         chk("tbl.full", int'(full), int'(tbl[i].fl));
         chk("tbl.low_wm", int'(low_wm), int'(tbl[i].lw));
         if (tbl[i].req) begin
            chk("tbl.pix_valid", int'(bus.pix_valid), 1);
            chk("tbl.pix_out", int'(bus.pix_out), int'(tbl[i].px));
         end
      end
      chk("tbl.empty_end", int'(empty), 1);

      for (int i = 0; i < 3; i++) drive("ss.fill", 1'b1, 16'($urandom), 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) drive("ss", 1'b1, 16'($urandom), 1'b1);
         else            drive("ss", 1'b0, 16'h0, 1'b1);
         chk("ss.max_level", int'(level <= 4'd8), 1);
         chk("ss.no_underflow", int'(underflow), 0);
      end
      for (int k = 0; k < 40 && !empty; k++) drive("drain", 1'b0, 16'h0, 1'b1);
      chk("drain.empty", int'(empty), 1);

      saved = bus.pix_out;
      drive("uf.req", 1'b0, 16'h0, 1'b1);
      chk("uf.set", int'(underflow), 1);
      chk("uf.pix_valid", int'(bus.pix_valid), 0);
      chk("uf.pix_out_hold", int'(bus.pix_out), int'(saved));
      drive("uf.write", 1'b1, 16'h5A6B, 1'b0);
      chk("uf.sticky", int'(underflow), 1);
      clr_err = 1'b1;
      drive("uf.clr", 1'b0, 16'h0, 1'b0);
      clr_err = 1'b0;
      chk("uf.cleared", int'(underflow), 0);
      drive("uf.pop0", 1'b0, 16'h0, 1'b1);
      chk("uf.pop0_px", int'(bus.pix_out), 8'h5A);
      drive("uf.pop1", 1'b0, 16'h0, 1'b1);
      chk("uf.pop1_px", int'(bus.pix_out), 8'h6B);
      clr_err = 1'b1;
      drive("uf.clr_vs_set", 1'b0, 16'h0, 1'b1);
      chk("uf.set_wins", int'(underflow), 1);
      drive("uf.clr2", 1'b0, 16'h0, 1'b0);
      clr_err = 1'b0;

      for (int i = 0; i < 3; i++) drive("fl.fill", 1'b1, 16'($urandom), 1'b0);
      drive("fl.pop", 1'b0, 16'h0, 1'b1);
      chk("fl.pre_level", int'(level), 5);
      flush = 1'b1;
      drive("fl.flush", 1'b0, 16'h0, 1'b0);
      flush = 1'b0;
      chk("fl.level", int'(level), 0);
      chk("fl.empty", int'(empty), 1);

      drive("en.fill", 1'b1, 16'h1122, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive("en.off", 1'b1, 16'h3344, 1'b1);
         chk("en.level_hold", int'(level), 2);
         chk("en.no_uf", int'(underflow), 0);
      end
      en = 1'b1;
      drive("en.pop0", 1'b0, 16'h0, 1'b1);
      chk("en.pop0_px", int'(bus.pix_out), 8'h11);
      drive("en.pop1", 1'b0, 16'h0, 1'b1);
      chk("en.pop1_px", int'(bus.pix_out), 8'h22);

      drive("ar.fill0", 1'b1, 16'h99AA, 1'b0);
      drive("ar.fill1", 1'b1, 16'hBBCC, 1'b0);
      drive("ar.pop", 1'b0, 16'h0, 1'b1);
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("ar.level", int'(level), 0);
      chk("ar.pix_valid", int'(bus.pix_valid), 0);
      chk("ar.pix_out", int'(bus.pix_out), 0);
      chk("ar.empty", int'(empty), 1);
      chk("ar.full", int'(full), 0);
      chk("ar.underflow", int'(underflow), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      drive("ar.idle", 1'b0, 16'h0, 1'b0);
      drive("ar.write", 1'b1, 16'hDEAD, 1'b0);
      drive("ar.pop", 1'b0, 16'h0, 1'b1);
      chk("ar.first_px", int'(bus.pix_out), 8'hDE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
